// File: rtl/approx_pkg.sv
// approx_pkg: shared widths and FSM state encoding for the approximate-multiplier error statistics block
package approx_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 21;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/approx_err_dist.sv
// approx_err_dist: absolute distance between exact and approximate product
// (plus signed c - exact when APPROX_STATS_BIAS_EN is defined)
module approx_err_dist
  import approx_pkg::*;
(
  input  logic [PROD_W-1:0]        i_exact,
  input  logic [PROD_W-1:0]        i_c,
`ifdef APPROX_STATS_BIAS_EN
  output logic signed [PROD_W:0]   o_sd,
`endif
  output logic [PROD_W-1:0]        o_ed
);
  assign o_ed = i_exact >= i_c ? i_exact - i_c : i_c - i_exact;
`ifdef APPROX_STATS_BIAS_EN
  assign o_sd = $signed({1'b0, i_c}) - $signed({1'b0, i_exact});
`endif
endmodule

// File: rtl/approx_err_stats.sv
// approx_err_stats: two-stage error-distance statistics over N_SAMPLES multiplier samples
// Optional signed bias accumulator enabled by defining APPROX_STATS_BIAS_EN.
module approx_err_stats
  import approx_pkg::*;
#(
  parameter int N_SAMPLES = 65536,
  parameter int ACC_W     = 40
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        a,
  input  logic [OP_W-1:0]        b,
  input  logic [PROD_W-1:0]      c,
  output logic [ACC_W-1:0]       sum_ed,
  output logic [PROD_W-1:0]      max_ed,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W-1:0]       smp_cnt,
`ifdef APPROX_STATS_BIAS_EN
  output logic signed [ACC_W:0]  bias_sum,
`endif
  output logic                   done
);
  localparam int SW = (ACC_W > PROD_W ? ACC_W : PROD_W) + 1;
  localparam logic [SW-1:0] SMAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  state_t            r_state;
  logic              r_ready, r_done, r_v1, r_v2;
  logic [PROD_W-1:0] r_exact, r_c, r_ed, r_max;
  logic [ACC_W-1:0]  r_sum;
  logic [CNT_W-1:0]  r_err, r_smp;
  logic              w_acc, w_go;
  logic [PROD_W-1:0] w_ed;
  logic [SW-1:0]     w_sum;

  assign w_acc = in_valid && r_ready && !clear;
  assign w_go  = start && !clear && (r_state == IDLE || r_state == DONE);
  assign w_sum = SW'(r_sum) + SW'(r_ed);

  assign in_ready = r_ready;
  assign done     = r_done;
  assign sum_ed   = r_sum;
  assign max_ed   = r_max;
  assign err_cnt  = r_err;
  assign smp_cnt  = r_smp;

`ifdef APPROX_STATS_BIAS_EN
  localparam int BW = (ACC_W > PROD_W ? ACC_W : PROD_W) + 2;
  localparam logic signed [BW-1:0] BMAX = BW'({ACC_W{1'b1}});
  localparam logic signed [BW-1:0] BMIN = -BMAX - BW'(1);
  logic signed [PROD_W:0] r_sd, w_sd;
  logic signed [ACC_W:0]  r_bias;
  logic signed [BW-1:0]   w_bias;
  assign w_bias   = BW'(r_bias) + BW'(r_sd);
  assign bias_sum = r_bias;
`endif

  approx_err_dist u_dist (
    .i_exact (r_exact),
    .i_c     (r_c),
`ifdef APPROX_STATS_BIAS_EN
    .o_sd    (w_sd),
`endif
    .o_ed    (w_ed)
  );

  // Sample N_SAMPLES leaves RUN; DONE waits until stage 1 is empty so the
  // last sample commits to the statistics on the same edge done rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_smp   <= '0;
    end else if (clear) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_smp   <= '0;
    end else if (w_go) begin
      r_state <= RUN;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_smp   <= '0;
    end else if (w_acc) begin
      r_smp <= r_smp + CNT_W'(1);
      if (r_smp == LAST) begin
        r_state <= DRAIN;
        r_ready <= 1'b0;
      end
    end else if (r_state == DRAIN && !r_v1) begin
      r_state <= DONE;
      r_done  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_exact <= '0;
      r_c     <= '0;
      r_ed    <= '0;
`ifdef APPROX_STATS_BIAS_EN
      r_sd    <= '0;
`endif
    end else begin
      r_v1 <= w_acc;
      r_v2 <= r_v1 && !clear;
      if (w_acc) begin
        r_exact <= PROD_W'(a) * PROD_W'(b);
        r_c     <= c;
      end
      if (r_v1) begin
        r_ed <= w_ed;
`ifdef APPROX_STATS_BIAS_EN
        r_sd <= w_sd;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_max <= '0;
      r_err <= '0;
`ifdef APPROX_STATS_BIAS_EN
      r_bias <= '0;
`endif
    end else if (clear || w_go) begin
      r_sum <= '0;
      r_max <= '0;
      r_err <= '0;
`ifdef APPROX_STATS_BIAS_EN
      r_bias <= '0;
`endif
    end else if (r_v2) begin
      r_sum <= w_sum > SMAX ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
      r_max <= r_ed > r_max ? r_ed : r_max;
      r_err <= r_err + CNT_W'(r_ed != '0);
`ifdef APPROX_STATS_BIAS_EN
      r_bias <= w_bias > BMAX ? BMAX[ACC_W:0] : w_bias < BMIN ? BMIN[ACC_W:0] : w_bias[ACC_W:0];
`endif
    end
  end
endmodule

// File: tb/tb_approx_err_stats.sv
// tb_approx_err_stats: randomized and directed checks of approx_err_stats against a sample-list model
module tb_approx_err_stats;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [15:0] c = '0;
  logic [39:0] sum4, sum2;
  logic [3:0] sum3;
  logic [15:0] max4, max2, max3;
  logic [20:0] err4, smp4, err2, smp2, err3, smp3;
  logic rdy4, rdy2, rdy3, done4, done2, done3;
`ifdef APPROX_STATS_BIAS_EN
  logic signed [40:0] bias4, bias2;
  logic signed [4:0] bias3;
`endif
  int total = 0, bad = 0;
  logic [7:0] da [4] = '{8'd3, 8'd3, 8'd255, 8'd2};
  logic [7:0] db [4] = '{8'd5, 8'd5, 8'd255, 8'd2};
  logic [15:0] dc [4] = '{16'd15, 16'd14, 16'd65025, 16'd0};
  int de [4] = '{0, 1, 0, 4};

  always #5 clk = ~clk;

  approx_err_stats #(.N_SAMPLES(4), .ACC_W(40)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .in_valid(in_valid), .in_ready(rdy4),
    .a(a), .b(b), .c(c), .sum_ed(sum4), .max_ed(max4), .err_cnt(err4), .smp_cnt(smp4),
`ifdef APPROX_STATS_BIAS_EN
    .bias_sum(bias4),
`endif
    .done(done4));

  approx_err_stats #(.N_SAMPLES(2), .ACC_W(40)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .in_valid(in_valid), .in_ready(rdy2),
    .a(a), .b(b), .c(c), .sum_ed(sum2), .max_ed(max2), .err_cnt(err2), .smp_cnt(smp2),
`ifdef APPROX_STATS_BIAS_EN
    .bias_sum(bias2),
`endif
    .done(done2));

  approx_err_stats #(.N_SAMPLES(3), .ACC_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .in_valid(in_valid), .in_ready(rdy3),
    .a(a), .b(b), .c(c), .sum_ed(sum3), .max_ed(max3), .err_cnt(err3), .smp_cnt(smp3),
`ifdef APPROX_STATS_BIAS_EN
    .bias_sum(bias3),
`endif
    .done(done3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  function automatic int abs_err(int x, int y);
    return x > y ? x - y : y - x;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", rdy4); end
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done4); end
    total++; if (sum4 !== '0 || max4 !== '0) begin bad++; $display("FAIL rst_sum_max got=%0d/%0d want=0/0", sum4, max4); end
    total++; if (err4 !== '0 || smp4 !== '0) begin bad++; $display("FAIL rst_counts got=%0d/%0d want=0/0", err4, smp4); end
    total++; if ({rdy2, rdy3, done2, done3} !== 4'b0) begin bad++; $display("FAIL rst_others got=%b want=0000", {rdy2, rdy3, done2, done3}); end
    rst_n = 1'b1;
    in_valid = 1'b1;
    tick;
    tick;
    total++; if (rdy4 !== 1'b0 || smp4 !== '0) begin bad++; $display("FAIL idle_no_accept got rdy=%0b smp=%0d want 0/0", rdy4, smp4); end
    in_valid = 1'b0;
  endtask

  task automatic test_directed;
    int s;
    do_clear;
    pulse_start;
    total++; if (rdy4 !== 1'b1 || smp4 !== '0) begin bad++; $display("FAIL dir_start got rdy=%0b smp=%0d want 1/0", rdy4, smp4); end
    s = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = da[i]; b = db[i]; c = dc[i];
      tick;
      if (i >= 2) s += de[i-2];
      total++; if (smp4 !== 21'(i + 1) || sum4 !== 40'(s)) begin bad++; $display("FAIL dir_step%0d got smp=%0d sum=%0d want %0d/%0d", i, smp4, sum4, i + 1, s); end
    end
    total++; if (rdy4 !== 1'b0 || done4 !== 1'b0) begin bad++; $display("FAIL dir_last got rdy=%0b done=%0b want 0/0", rdy4, done4); end
    tick;
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL dir_done_early got=%0b want=0", done4); end
    tick;
    total++; if (done4 !== 1'b1) begin bad++; $display("FAIL dir_done got=%0b want=1", done4); end
    total++; if (sum4 !== 40'd5 || max4 !== 16'd4) begin bad++; $display("FAIL dir_sum_max got=%0d/%0d want=5/4", sum4, max4); end
    total++; if (err4 !== 21'd2 || smp4 !== 21'd4) begin bad++; $display("FAIL dir_counts got=%0d/%0d want=2/4", err4, smp4); end
    in_valid = 1'b0;
  endtask

  task automatic test_bubbles;
    int n;
    do_clear;
    pulse_start;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2) == 0; a = 8'($urandom); b = 8'($urandom); c = 16'(int'(a) * int'(b));
      tick;
      if (in_valid) n++;
      total++; if (rdy2 !== (n < 2) || smp2 !== 21'(n) || done2 !== 1'b0) begin bad++; $display("FAIL bub_step%0d got rdy=%0b smp=%0d done=%0b want %0b/%0d/0", i, rdy2, smp2, done2, n < 2, n); end
    end
    tick;
    total++; if (done2 !== 1'b1 || sum2 !== '0 || err2 !== '0 || max2 !== '0 || smp2 !== 21'd2) begin bad++; $display("FAIL bub_final got done=%0b sum=%0d err=%0d max=%0d smp=%0d want 1/0/0/0/2", done2, sum2, err2, max2, smp2); end
  endtask

  task automatic test_saturate;
    int ex;
    do_clear;
    pulse_start;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 8'($urandom_range(0, 200)); b = 8'($urandom);
      ex = int'(a) * int'(b);
      c = 16'((ex < 10 || $urandom % 2 == 0) ? ex + 10 : ex - 10);
      tick;
    end
    in_valid = 1'b0;
    total++; if (sum3 !== 4'd10 || rdy3 !== 1'b0) begin bad++; $display("FAIL sat_first got sum=%0d rdy=%0b want 10/0", sum3, rdy3); end
    tick;
    total++; if (sum3 !== 4'd15) begin bad++; $display("FAIL sat_clip got=%0d want=15", sum3); end
    tick;
    total++; if (sum3 !== 4'd15 || max3 !== 16'd10 || err3 !== 21'd3 || done3 !== 1'b1) begin bad++; $display("FAIL sat_final got sum=%0d max=%0d err=%0d done=%0b want 15/10/3/1", sum3, max3, err3, done3); end
  endtask

  task automatic test_clear;
    do_clear;
    pulse_start;
    in_valid = 1'b1; a = 8'd10; b = 8'd10; c = 16'd200;
    tick;
    total++; if (smp4 !== 21'd1) begin bad++; $display("FAIL clr_accept got=%0d want=1", smp4); end
    clear = 1'b1; start = 1'b1;
    tick;
    clear = 1'b0; start = 1'b0;
    total++; if (rdy4 !== 1'b0 || done4 !== 1'b0 || smp4 !== '0) begin bad++; $display("FAIL clr_state got rdy=%0b done=%0b smp=%0d want 0/0/0", rdy4, done4, smp4); end
    total++; if (sum4 !== '0 || max4 !== '0 || err4 !== '0) begin bad++; $display("FAIL clr_stats got sum=%0d max=%0d err=%0d want 0", sum4, max4, err4); end
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 16'($urandom);
      tick;
      total++; if (sum4 !== '0 || max4 !== '0 || smp4 !== '0 || rdy4 !== 1'b0) begin bad++; $display("FAIL clr_stale%0d got sum=%0d max=%0d smp=%0d rdy=%0b want 0", i, sum4, max4, smp4, rdy4); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    int ex, d, s;
    do_clear;
    pulse_start;
    s = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      ex = int'(a) * int'(b); d = int'($urandom_range(1, 50));
      c = 16'(ex + d); s += d;
      tick;
    end
    in_valid = 1'b0;
    tick;
    tick;
    total++; if (sum4 !== 40'(s) || smp4 !== 21'd2 || rdy4 !== 1'b1) begin bad++; $display("FAIL ar_pre got sum=%0d smp=%0d rdy=%0b want %0d/2/1", sum4, smp4, rdy4, s); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (sum4 !== '0 || max4 !== '0 || err4 !== '0 || smp4 !== '0 || rdy4 !== 1'b0 || done4 !== 1'b0) begin bad++; $display("FAIL ar_async got sum=%0d max=%0d err=%0d smp=%0d rdy=%0b done=%0b want 0", sum4, max4, err4, smp4, rdy4, done4); end
    #2 rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (rdy4 !== 1'b0 || smp4 !== '0) begin bad++; $display("FAIL ar_idle%0d got rdy=%0b smp=%0d want 0/0", i, rdy4, smp4); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random;
    int acc_at[$], eds[$];
    int n, last, cyc, ex, t, s, m, e;
    logic v;
    for (int r = 0; r < 25; r++) begin
      acc_at.delete(); eds.delete();
      n = 0; last = -1;
      pulse_start;
      total++; if (sum4 !== '0 || max4 !== '0 || err4 !== '0 || smp4 !== '0 || rdy4 !== 1'b1) begin bad++; $display("FAIL rnd_start%0d got sum=%0d max=%0d err=%0d smp=%0d rdy=%0b want 0/0/0/0/1", r, sum4, max4, err4, smp4, rdy4); end
      for (cyc = 1; cyc < 200; cyc++) begin
        v = ($urandom % 4) != 0;
        in_valid = v; a = 8'($urandom); b = 8'($urandom);
        ex = int'(a) * int'(b);
        case ($urandom % 3)
          0: c = 16'(ex);
          1: begin t = ex + int'($urandom_range(0, 200)) - 100; c = 16'(t < 0 ? 0 : t > 65535 ? 65535 : t); end
          default: c = 16'($urandom);
        endcase
        start = (last < 0 || cyc <= last + 2) && ($urandom % 16 == 0);
        tick;
        if (v && n < 4) begin
          acc_at.push_back(cyc); eds.push_back(abs_err(ex, int'(c))); n++;
          if (n == 4) last = cyc;
        end
        s = 0; m = 0; e = 0;
        foreach (eds[j]) if (acc_at[j] <= cyc - 2) begin
          s += eds[j];
          if (eds[j] > m) m = eds[j];
          if (eds[j] != 0) e++;
        end
        total++;
        if ({sum4, max4, err4, smp4, rdy4, done4} !== {40'(s), 16'(m), 21'(e), 21'(n), n < 4, last >= 0 && cyc >= last + 2}) begin
          bad++;
          $display("FAIL rnd r%0d c%0d got sum=%0d max=%0d err=%0d smp=%0d rdy=%0b done=%0b want sum=%0d max=%0d err=%0d smp=%0d rdy=%0b done=%0b",
                   r, cyc, sum4, max4, err4, smp4, rdy4, done4, s, m, e, n, n < 4, last >= 0 && cyc >= last + 2);
        end
        if (last >= 0 && cyc == last + 3) break;
      end
      start = 1'b0; in_valid = 1'b0;
      total++; if (last < 0 || cyc >= 200) begin bad++; $display("FAIL rnd_timeout r%0d got accepts=%0d want 4", r, n); end
    end
  endtask

`ifdef APPROX_STATS_BIAS_EN
  task automatic test_bias;
    int ex;
    do_clear;
    pulse_start;
    in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
    ex = int'(a) * int'(b); c = 16'(ex + 7);
    tick;
    a = 8'($urandom_range(2, 255)); b = 8'($urandom_range(2, 255));
    ex = int'(a) * int'(b); c = 16'(ex - 3);
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    total++; if (bias4 !== 41'sd4 || sum4 !== 40'd10) begin bad++; $display("FAIL bias got bias=%0d sum=%0d want 4/10", bias4, sum4); end
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_bubbles;
    test_saturate;
    test_clear;
    test_async_reset;
    test_random;
`ifdef APPROX_STATS_BIAS_EN
    test_bias;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
